anim_scheduler: RTL and testbench
=================================

Name: anim_scheduler

Overview:
- Sequences the 4-bit mode bus that drives the cat/dog/mouse frame-pattern block.
- Accepts play requests from three animals and grants one at a time, round-robin.
- Steps the granted animal through frames 1→2→3→0, holding each for HOLD ticks, repeating LOOPS times, then hands over.
- Sits between the button/debounce logic and the frame-pattern block; runs on the 1 Hz animation clock.

Parameters:
- HOLD, 1: ticks each of frames 1..3 is held (≥1). Frame 0 is always held 1 tick.
- LOOPS, 1: full 1→2→3→0 cycles per grant (≥1).

Ports:
- clk1hz, input, 1: animation clock; all logic on its rising edge.
- rst, input, 1: synchronous, active-low reset; sampled only on the clk1hz rising edge.
- req, input, 3: play requests; bit0 cat, bit1 dog, bit2 mouse. Level-sampled each edge.
- mode, output, 4: {animal_id[1:0], frame[1:0]}. Animal ids: cat 00, dog 01, mouse 10. Idle code is 4'b1100 (no-op to the pattern block).
- grant, output, 3: one-hot active animal; 0 when idle.
- busy, output, 1: high while an animal is granted.
- done, output, 1: one-tick pulse on the final frame-0 tick of a grant.
- abort, input, 1: exists only with ANIM_ABORT_EN.

Behaviour:
- Reset values (rst=0 at an edge):
  - State IDLE; mode=4'b1100; grant=0; busy=0; done=0; pending=0.
  - RR pointer = mouse, so cat has first priority.
  - Hold and loop counters are 0.
  - Reset mid-operation aborts immediately. No frame-0 step is emitted.
- pending[2:0] latches req bits every edge; a bit is cleared on the edge its animal is granted.
  - Clear wins over a simultaneous set for the same bit, so a request on the grant edge is absorbed.
  - A request from the active animal during its play is latched and replayed later.
- Arbitration uses cand = pending | req.
  - It runs on any edge in IDLE, and on the edge ending the final HOME tick.
  - Search order starts at the animal after the last grant: cat→dog→mouse→cat.
  - cand=0 → IDLE.
- States:
  - IDLE: mode=1100. If cand≠0, grant the winner: state PLAY, frame=1, hold=0, loop=0.
  - PLAY: mode={id,frame}.
    - hold increments each tick.
    - When hold==HOLD-1: frame 1→2, 2→3, 3→HOME, and hold resets.
  - HOME: mode={id,2'b00} for exactly 1 tick.
    - If loop<LOOPS-1: loop++ and go to PLAY frame 1.
    - Otherwise assert done this tick. On the next edge, arbitrate: go to PLAY for the new winner (back-to-back, no idle gap), or to IDLE.
- Latency: req high at edge N in IDLE → after edge N mode={id,01}, busy=1, grant set.
- Grant duration is LOOPS*(3*HOLD+1) ticks.
- All outputs are registered. grant, busy and mode change together.
- Counter widths: hold is $clog2(HOLD+1); loop is $clog2(LOOPS+1). No wrap occurs within the legal range.

Optional Feature:
- ANIM_ABORT_EN defined:
  - Adds the abort input.
  - abort=1 at an edge in PLAY → next tick is HOME (mode={id,00}, done=1); remaining loops are discarded; then normal arbitration.
  - abort is ignored in IDLE and HOME.
- ANIM_ABORT_EN undefined: no abort port; every grant completes all loops.

Decomposition:
- Package anim_pkg holds:
  - Animal id constants: ID_CAT=2'b00, ID_DOG=2'b01, ID_MOUSE=2'b10.
  - MODE_IDLE=4'b1100.
  - Frame constants F0..F3.
  - The state enum {IDLE, PLAY, HOME}.
- Sub-module rr_arbiter3 is natural: 3-bit cand plus last-grant pointer in, one-hot winner plus id out. It is purely combinational; the pointer register stays in the parent.

Test Plan:
1. Reset then req=001 for one tick (HOLD=1, LOOPS=1) → mode 0001, 0010, 0011, 0000 (done=1), then 1100, busy=0.
2. req=111 held for one tick from IDLE → grants in order cat, dog, mouse, back-to-back.
   - Mode stream: 0001..0000, 0101..0100, 1001..1000.
   - Exactly 3 done pulses, no 1100 between grants.
3. HOLD=2, LOOPS=2, req=010 → 0101×2, 0110×2, 0111×2, 0100, repeat; done only on the 14th tick.
4. Cat playing and req=001 pulsed during frame 2 → after cat's HOME, cat replays from 0001; a request pulsed on the grant edge itself is not replayed.
5. rst=0 during dog frame 3 with pending mouse → next tick mode=1100, grant=0, pending cleared. After release, req=101 grants cat first.
6. ANIM_ABORT_EN: abort during mouse frame 1 with LOOPS=3 → next tick 1000 with done=1, then 1100; abort in IDLE has no effect.

Source files
------------

// File: rtl/anim_pkg.sv
// Shared ids, mode codes, frame codes and FSM states for the animation scheduler.
package anim_pkg;

  localparam logic [1:0] ID_CAT   = 2'b00;
  localparam logic [1:0] ID_DOG   = 2'b01;
  localparam logic [1:0] ID_MOUSE = 2'b10;

  localparam logic [3:0] MODE_IDLE = 4'b1100;

  localparam logic [1:0] F0 = 2'b00;
  localparam logic [1:0] F1 = 2'b01;
  localparam logic [1:0] F2 = 2'b10;
  localparam logic [1:0] F3 = 2'b11;

  typedef enum logic [1:0] {IDLE, PLAY, HOME} state_t;

  // Round-robin successor: cat -> dog -> mouse -> cat.
  function automatic logic [1:0] next_id(input logic [1:0] id);
    case (id)
      ID_CAT:  return ID_DOG;
      ID_DOG:  return ID_MOUSE;
      default: return ID_CAT;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Combinational 3-way round-robin pick starting after the last granted id.
// Latency 0; no backpressure, winner is zero when cand is zero.
module rr_arbiter3
  import anim_pkg::*;
(
  input  logic [2:0] cand,
  input  logic [1:0] last,
  output logic [2:0] win,
  output logic [1:0] win_id
);

  logic [1:0] c0, c1, c2;

  always_comb begin
    c0     = next_id(last);
    c1     = next_id(c0);
    c2     = next_id(c1);
    win_id = c0;
    // Lowest priority first so the highest-priority hit is assigned last.
    if (cand[c2]) win_id = c2;
    if (cand[c1]) win_id = c1;
    if (cand[c0]) win_id = c0;
    win = (|cand) ? (3'b001 << win_id) : 3'b000;
  end

endmodule

// File: rtl/anim_scheduler.sv
// Round-robin play scheduler driving the frame-pattern mode bus; req to first frame in 1 tick.
// No backpressure: requests are latched in pending and replayed; optional abort via ANIM_ABORT_EN.
module anim_scheduler
  import anim_pkg::*;
#(
  parameter int HOLD  = 1,
  parameter int LOOPS = 1
) (
  input  logic       clk1hz,
  input  logic       rst,
  input  logic [2:0] req,
`ifdef ANIM_ABORT_EN
  input  logic       abort,
`endif
  output logic [3:0] mode,
  output logic [2:0] grant,
  output logic       busy,
  output logic       done
);

  localparam int HW = $clog2(HOLD + 1);
  localparam int LW = $clog2(LOOPS + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
  localparam logic [LW-1:0] LOOP_LAST = LW'(LOOPS - 1);

  state_t          state;
  logic [1:0]      id, frame, last;
  logic [HW-1:0]   hold;
  logic [LW-1:0]   loop;
  logic [2:0]      pending, cand, win;
  logic [1:0]      win_id, frame_nxt;
  logic            abort_i, arb_go, grant_now;

`ifdef ANIM_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif

  assign cand      = pending | req;
  assign arb_go    = (state == IDLE) || (state == HOME && loop == LOOP_LAST);
  assign grant_now = arb_go && (|cand);
  assign frame_nxt = frame + 2'd1;

  rr_arbiter3 u_arb (
    .cand   (cand),
    .last   (last),
    .win    (win),
    .win_id (win_id)
  );

  always_ff @(posedge clk1hz) begin
    if (!rst) begin
      state   <= IDLE;
      id      <= ID_CAT;
      frame   <= F0;
      last    <= ID_MOUSE;
      hold    <= '0;
      loop    <= '0;
      pending <= '0;
      mode    <= MODE_IDLE;
      grant   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      // A grant clears its own bit, absorbing a request on the same edge.
      pending <= cand & ~(grant_now ? win : 3'b000);
      done    <= 1'b0;
      if (arb_go) begin
        if (grant_now) begin
          state <= PLAY;
          id    <= win_id;
          last  <= win_id;
          frame <= F1;
          hold  <= '0;
          loop  <= '0;
          mode  <= {win_id, F1};
          grant <= win;
          busy  <= 1'b1;
        end else begin
          state <= IDLE;
          mode  <= MODE_IDLE;
          grant <= '0;
          busy  <= 1'b0;
        end
      end else if (state == HOME) begin
        loop  <= loop + 1'b1;
        state <= PLAY;
        frame <= F1;
        hold  <= '0;
        mode  <= {id, F1};
      end else begin
        hold <= hold + 1'b1;
        if (abort_i || hold == HOLD_LAST) begin
          hold <= '0;
          if (abort_i || frame == F3) begin
            state <= HOME;
            frame <= F0;
            mode  <= {id, F0};
            if (abort_i) loop <= LOOP_LAST;
            done  <= abort_i || (loop == LOOP_LAST);
          end else begin
            frame <= frame_nxt;
            mode  <= {id, frame_nxt};
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_anim_scheduler.sv
// Directed self-checking bench for anim_scheduler across three HOLD/LOOPS configurations.
module tb_anim_scheduler;

  logic       clk1hz = 1'b0;
  logic       rst    = 1'b0;
  logic [2:0] req    = 3'b000;
  logic       abort  = 1'b0;

  logic [3:0] mode_a, mode_b, mode_c;
  logic [2:0] grant_a, grant_b, grant_c;
  logic       busy_a, busy_b, busy_c;
  logic       done_a, done_b, done_c;

  int checks = 0;
  int errors = 0;

  always #5 clk1hz = ~clk1hz;

  anim_scheduler #(.HOLD(1), .LOOPS(1)) dut_a (
    .clk1hz(clk1hz), .rst(rst), .req(req),
`ifdef ANIM_ABORT_EN
    .abort(abort),
`endif
    .mode(mode_a), .grant(grant_a), .busy(busy_a), .done(done_a)
  );

  anim_scheduler #(.HOLD(2), .LOOPS(2)) dut_b (
    .clk1hz(clk1hz), .rst(rst), .req(req),
`ifdef ANIM_ABORT_EN
    .abort(abort),
`endif
    .mode(mode_b), .grant(grant_b), .busy(busy_b), .done(done_b)
  );

  anim_scheduler #(.HOLD(1), .LOOPS(3)) dut_c (
    .clk1hz(clk1hz), .rst(rst), .req(req),
`ifdef ANIM_ABORT_EN
    .abort(abort),
`endif
    .mode(mode_c), .grant(grant_c), .busy(busy_c), .done(done_c)
  );

  task automatic tick();
    @(posedge clk1hz);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; req = 3'b000; abort = 1'b0;
    tick(); tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({mode_a, grant_a, busy_a, done_a} !== {4'b1100, 3'b000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_a got mode=%b grant=%b busy=%b done=%b exp 1100/000/0/0", mode_a, grant_a, busy_a, done_a);
    end
    checks++;
    if ({mode_b, grant_b, busy_b, done_b} !== {4'b1100, 3'b000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_b got mode=%b grant=%b busy=%b done=%b exp 1100/000/0/0", mode_b, grant_b, busy_b, done_b);
    end
  endtask

  task automatic test_single();
    logic [3:0] exp_m [5] = '{4'b0001, 4'b0010, 4'b0011, 4'b0000, 4'b1100};
    logic       exp_d [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       exp_b [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    req = 3'b001;
    for (int i = 0; i < 5; i++) begin
      tick();
      req = 3'b000;
      checks++;
      if (mode_a !== exp_m[i] || done_a !== exp_d[i] || busy_a !== exp_b[i]) begin
        errors++;
        $display("FAIL single[%0d] got mode=%b done=%b busy=%b exp %b/%b/%b", i, mode_a, done_a, busy_a, exp_m[i], exp_d[i], exp_b[i]);
      end
    end
    checks++;
    if (grant_a !== 3'b000) begin
      errors++;
      $display("FAIL single_grant_idle got %b exp 000", grant_a);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_m [13] = '{4'b0001, 4'b0010, 4'b0011, 4'b0000,
                               4'b0101, 4'b0110, 4'b0111, 4'b0100,
                               4'b1001, 4'b1010, 4'b1011, 4'b1000, 4'b1100};
    logic [2:0] exp_g [13] = '{3'b001, 3'b001, 3'b001, 3'b001,
                               3'b010, 3'b010, 3'b010, 3'b010,
                               3'b100, 3'b100, 3'b100, 3'b100, 3'b000};
    int dones = 0;
    do_reset();
    req = 3'b111;
    for (int i = 0; i < 13; i++) begin
      tick();
      req = 3'b000;
      if (done_a) dones++;
      checks++;
      if (mode_a !== exp_m[i] || grant_a !== exp_g[i]) begin
        errors++;
        $display("FAIL b2b[%0d] got mode=%b grant=%b exp %b/%b", i, mode_a, grant_a, exp_m[i], exp_g[i]);
      end
    end
    checks++;
    if (dones !== 3) begin
      errors++;
      $display("FAIL b2b_done_count got %0d exp 3", dones);
    end
  endtask

  task automatic test_hold_loops();
    logic [3:0] exp_m [15] = '{4'b0101, 4'b0101, 4'b0110, 4'b0110, 4'b0111, 4'b0111, 4'b0100,
                               4'b0101, 4'b0101, 4'b0110, 4'b0110, 4'b0111, 4'b0111, 4'b0100,
                               4'b1100};
    do_reset();
    req = 3'b010;
    for (int i = 0; i < 15; i++) begin
      tick();
      req = 3'b000;
      checks++;
      if (mode_b !== exp_m[i] || done_b !== (i == 13)) begin
        errors++;
        $display("FAIL hold_loops[%0d] got mode=%b done=%b exp %b/%b", i, mode_b, done_b, exp_m[i], (i == 13));
      end
    end
  endtask

  task automatic test_loops3();
    int dones = 0;
    do_reset();
    req = 3'b100;
    for (int i = 0; i < 12; i++) begin
      tick();
      req = 3'b000;
      if (done_c) dones++;
      if (i == 3) begin
        checks++;
        if (mode_c !== 4'b1000 || done_c !== 1'b0) begin
          errors++;
          $display("FAIL loops3_home1 got mode=%b done=%b exp 1000/0", mode_c, done_c);
        end
      end
    end
    checks++;
    if (mode_c !== 4'b1000 || done_c !== 1'b1 || dones !== 1) begin
      errors++;
      $display("FAIL loops3_end got mode=%b done=%b dones=%0d exp 1000/1/1", mode_c, done_c, dones);
    end
    tick();
    checks++;
    if (mode_c !== 4'b1100 || busy_c !== 1'b0) begin
      errors++;
      $display("FAIL loops3_idle got mode=%b busy=%b exp 1100/0", mode_c, busy_c);
    end
  endtask

  task automatic test_replay();
    logic [3:0] exp_m [9] = '{4'b0011, 4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0000, 4'b1100, 4'b1100, 4'b1100};
    do_reset();
    req = 3'b001;
    tick();
    req = 3'b000;
    tick();
    checks++;
    if (mode_a !== 4'b0010) begin
      errors++;
      $display("FAIL replay_f2 got %b exp 0010", mode_a);
    end
    req = 3'b001;
    for (int i = 0; i < 9; i++) begin
      tick();
      req = 3'b000;
      checks++;
      if (mode_a !== exp_m[i]) begin
        errors++;
        $display("FAIL replay[%0d] got mode=%b exp %b", i, mode_a, exp_m[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    req = 3'b110;
    tick();
    req = 3'b000;
    tick(); tick();
    checks++;
    if (mode_a !== 4'b0111) begin
      errors++;
      $display("FAIL midrst_f3 got %b exp 0111", mode_a);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (mode_a !== 4'b1100 || grant_a !== 3'b000 || busy_a !== 1'b0 || done_a !== 1'b0) begin
      errors++;
      $display("FAIL midrst_out got mode=%b grant=%b busy=%b done=%b exp 1100/000/0/0", mode_a, grant_a, busy_a, done_a);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (mode_a !== 4'b1100 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL midrst_pending got mode=%b busy=%b exp 1100/0", mode_a, busy_a);
    end
    req = 3'b101;
    tick();
    req = 3'b000;
    checks++;
    if (mode_a !== 4'b0001 || grant_a !== 3'b001) begin
      errors++;
      $display("FAIL midrst_cat_first got mode=%b grant=%b exp 0001/001", mode_a, grant_a);
    end
    tick(); tick(); tick(); tick();
    checks++;
    if (mode_a !== 4'b1001 || grant_a !== 3'b100) begin
      errors++;
      $display("FAIL midrst_mouse_next got mode=%b grant=%b exp 1001/100", mode_a, grant_a);
    end
  endtask

`ifdef ANIM_ABORT_EN
  task automatic test_abort();
    do_reset();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (mode_c !== 4'b1100 || busy_c !== 1'b0 || done_c !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle got mode=%b busy=%b done=%b exp 1100/0/0", mode_c, busy_c, done_c);
    end
    req = 3'b100;
    tick();
    req = 3'b000;
    checks++;
    if (mode_c !== 4'b1001) begin
      errors++;
      $display("FAIL abort_start got %b exp 1001", mode_c);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (mode_c !== 4'b1000 || done_c !== 1'b1) begin
      errors++;
      $display("FAIL abort_home got mode=%b done=%b exp 1000/1", mode_c, done_c);
    end
    tick();
    checks++;
    if (mode_c !== 4'b1100 || busy_c !== 1'b0 || grant_c !== 3'b000) begin
      errors++;
      $display("FAIL abort_idle_after got mode=%b busy=%b grant=%b exp 1100/0/000", mode_c, busy_c, grant_c);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_hold_loops();
    test_loops3();
    test_replay();
    test_mid_reset();
`ifdef ANIM_ABORT_EN
    test_abort();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
